// File: rtl/forth_pkg.sv
// rtl/forth_pkg.sv - shared constants, operation codes and helpers for the Forth core stacks
package forth_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int PSTACK_DEPTH  = 16;

    // Stack operation as decoded from {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - spill array for the stacks: one synchronous write port, one combinational read port
module stack_ram
    import forth_pkg::*;
#(
    parameter int width      = DEFAULT_WIDTH,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rdata
);

    // One entry short of the address space: the NOS register holds the remaining entry
    logic [width-1:0] r_mem [0:(1 << addr_width) - 2];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pstack.sv
// rtl/pstack.sv - parameter stack holding NOS in a register and spilling deeper entries to stack_ram
module pstack
    import forth_pkg::*;
#(
    parameter int width     = DEFAULT_WIDTH,
    parameter int depth     = PSTACK_DEPTH,
    parameter int cnt_width = clog2(depth) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [width-1:0]     push_data,
    input  logic                 clear_err,
    output logic [width-1:0]     pstack_top,
    output logic [cnt_width-1:0] count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int addr_width = clog2(depth);

    logic [width-1:0]      r_top;
    logic [addr_width-1:0] r_sp;
    logic [cnt_width-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    stack_op_e             w_op;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_we;
    logic [addr_width-1:0] w_raddr;
    logic [width-1:0]      w_rdata;

    assign w_op    = stack_op_e'({push, pop});
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == cnt_width'(depth));
    // Only a push onto a non-empty, non-full stack spills the old NOS into the array
    assign w_we    = (w_op == OP_PUSH) && !w_full && !w_empty && !reset;
    assign w_raddr = r_sp - addr_width'(1);

    stack_ram #(
        .width      (width),
        .addr_width (addr_width)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_sp),
        .wdata (r_top),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_top       <= '0;
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // A new error raised below overrides this clear
            if (clear_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        if (!w_empty) begin
                            r_sp <= r_sp + addr_width'(1);
                        end
                        r_top   <= push_data;
                        r_count <= r_count + cnt_width'(1);
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        if (r_count > cnt_width'(1)) begin
                            r_top <= w_rdata;
                            r_sp  <= r_sp - addr_width'(1);
                        end else begin
                            r_top <= '0;
                        end
                        r_count <= r_count - cnt_width'(1);
                    end
                end
                OP_REPLACE: begin
                    r_top <= push_data;
                    if (w_empty) begin
                        r_count     <= cnt_width'(1);
                        r_underflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pstack_top = r_top;
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_pstack.sv
// tb/tb_pstack.sv - directed self-checking bench for pstack
module tb_pstack;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic [15:0] push_data;
    logic        clear_err;
    logic [15:0] pstack_top;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int n_checks;
    int n_errors;

    pstack dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_data  (push_data),
        .clear_err  (clear_err),
        .pstack_top (pstack_top),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (observed !== expected) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic rst, input logic ps, input logic pp,
                        input logic [15:0] d, input logic clr);
        reset     = rst;
        push      = ps;
        pop       = pp;
        push_data = d;
        clear_err = clr;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        clear_err = 1'b0;

        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        check("rst_count", count, 0);
        check("rst_top", pstack_top, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        step(0, 1, 0, 16'h1111, 0);
        check("push1_top", pstack_top, 16'h1111);
        step(0, 1, 0, 16'h2222, 0);
        check("push2_top", pstack_top, 16'h2222);
        step(0, 1, 0, 16'h3333, 0);
        check("push3_top", pstack_top, 16'h3333);
        check("push3_count", count, 3);

        step(0, 0, 1, 16'h0, 0);
        check("pop1_top", pstack_top, 16'h2222);
        step(0, 0, 1, 16'h0, 0);
        check("pop2_top", pstack_top, 16'h1111);
        step(0, 0, 1, 16'h0, 0);
        check("pop3_top", pstack_top, 16'h0000);
        check("pop3_count", count, 0);
        check("pop3_empty", empty, 1);
        check("pop3_udf", underflow, 0);

        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 16'(i), 0);
        end
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_top", pstack_top, 16'h000F);
        check("fill_ovf", overflow, 0);
        step(0, 1, 0, 16'hDEAD, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_top", pstack_top, 16'h000F);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        step(0, 0, 0, 16'h0, 1);
        check("ovf_clear", overflow, 0);

        step(0, 1, 1, 16'h7777, 0);
        check("repl_full_top", pstack_top, 16'h7777);
        check("repl_full_count", count, 16);
        check("repl_full_ovf", overflow, 0);
        check("repl_full_udf", underflow, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 0, 1, 16'h0, 0);
            check($sformatf("drain_top_%0d", i), pstack_top, 32'(15 - i));
            check($sformatf("drain_count_%0d", i), count, 32'(16 - i));
        end
        step(0, 0, 1, 16'h0, 0);
        check("drain_last_top", pstack_top, 0);
        check("drain_last_empty", empty, 1);
        check("drain_udf", underflow, 0);

        step(0, 1, 0, 16'hAAAA, 0);
        step(0, 1, 0, 16'hBBBB, 0);
        step(0, 1, 1, 16'hCCCC, 0);
        check("repl_top", pstack_top, 16'hCCCC);
        check("repl_count", count, 2);
        step(0, 0, 1, 16'h0, 0);
        check("repl_pop_top", pstack_top, 16'hAAAA);
        check("repl_pop_count", count, 1);
        step(0, 0, 1, 16'h0, 0);
        check("repl_pop2_empty", empty, 1);

        step(0, 0, 1, 16'h0, 0);
        check("udf_flag", underflow, 1);
        check("udf_count", count, 0);
        check("udf_top", pstack_top, 0);
        step(0, 0, 1, 16'h0, 1);
        check("udf_clr_race", underflow, 1);
        step(0, 0, 0, 16'h0, 1);
        check("udf_clear", underflow, 0);

        step(0, 1, 1, 16'h4242, 0);
        check("repl_empty_top", pstack_top, 16'h4242);
        check("repl_empty_count", count, 1);
        check("repl_empty_udf", underflow, 1);
        step(0, 0, 0, 16'h0, 1);

        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 16'(16'h0100 + i), 0);
        end
        check("pre_rst_count", count, 5);
        step(1, 1, 0, 16'h5555, 0);
        check("rst_push_count", count, 0);
        check("rst_push_top", pstack_top, 0);
        check("rst_push_ovf", overflow, 0);
        check("rst_push_udf", underflow, 0);
        step(0, 1, 0, 16'h0001, 0);
        check("post_rst_top", pstack_top, 16'h0001);
        check("post_rst_count", count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pstack.md
Name: pstack

Overview:
- Parameter (data) stack that sits directly upstream of the TOS datapath and provides pstack_top, the next-on-stack (NOS) value.
- The in-register TOS lives in the downstream stage. This block holds NOS in a dedicated register and spills deeper entries into a small LIFO array.
- The sequencer drives push (TOS spills down), pop (NOS moves up) or both (NOS is replaced).
- Depth tracking, full/empty status and sticky error flags support debug and trap logic.

Parameters:
- width, 16, data word width in bits.
- depth, 16, total entries including the NOS register; power of two, at least 2.
- cnt_width, $clog2(depth)+1, width of the occupancy counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  push push_data onto the stack this cycle.
- pop  input  1  pop the top entry this cycle.
- push_data  input  width  value to push; normally the downstream TOS.
- pstack_top  output  width  current top entry (NOS), driven straight from a register.
- count  output  cnt_width  number of valid entries, 0..depth.
- empty  output  1  count == 0.
- full  output  1  count == depth.
- overflow  output  1  sticky; set on a rejected push.
- underflow  output  1  sticky; set on a rejected pop.
- clear_err  input  1  clears overflow and underflow.

Behaviour:
- Reset (synchronous, active-high): count=0, pstack_top=0, overflow=0, underflow=0. Array contents are don't-care. Reset overrides every other input in the same cycle.
- State elements:
  - top_r drives pstack_top.
  - sp (log2(depth) bits) is the index of the next free array slot; it always equals count-1 when count>0, and 0 when empty.
  - The array has depth-1 entries, one synchronous write port and one combinational read port at sp-1.
- Operations, applied at the rising edge, decoded from {push,pop}:
  - 00 idle: no change.
  - 10 push, not full:
    - if count>0: array[sp] <= top_r and sp++;
    - top_r <= push_data;
    - count++.
  - 01 pop, not empty:
    - if count>1: top_r <= array[sp-1] and sp--;
    - if count==1: top_r <= 0;
    - count--.
  - 11 replace, not empty: top_r <= push_data; count and sp unchanged.
- Boundary rules:
  - Push while full: state unchanged, overflow<=1.
  - Pop while empty: state unchanged, underflow<=1, pstack_top stays 0.
  - 11 while empty: behaves as push (count becomes 1, top_r=push_data) and underflow<=1.
  - 11 while full: legal replace; no error.
  - clear_err in the same cycle as a new error: the error wins and the flag stays 1.
- Latency:
  - pstack_top reflects an operation in the cycle after the edge; no bubbles.
  - Back-to-back push/pop every cycle is supported with no read-after-write hazard. The NOS value is always in top_r; the array is read only on pop, at sp-1, which was never written in that same cycle.
- Width rules: count saturates by construction (it never exceeds depth or goes below 0); sp wraps are impossible given the guards above.
- empty and full are combinational decodes of count; no extra latency.

Decomposition:
- Shared package forth_pkg holds default width, default pstack depth and a clog2 helper constant function. The return stack reuses the same package.
- One sub-module, stack_ram:
  - parameters width and addr_width;
  - ports clk, we, waddr, wdata, raddr, rdata;
  - combinational read so it maps to distributed/LUT RAM.
- pstack instantiates stack_ram with depth-1 entries and contains the count/sp/top_r control and the error flags.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles → pstack_top 0x1111, 0x2222, 0x3333 on each following cycle; count=3.
- Continue from 3 entries: pop, pop, pop on consecutive cycles → pstack_top 0x2222, 0x1111, 0x0000; count=0; empty=1; underflow=0.
- Push depth (16) values 0..15, then push 0xDEAD → full=1, overflow=1, pstack_top=15, count=16. Then assert clear_err → overflow=0.
- With 2 entries (0xAAAA, 0xBBBB), assert push+pop with 0xCCCC → pstack_top=0xCCCC, count=2. Then pop → pstack_top=0xAAAA.
- Empty stack, pop → underflow=1, count=0. Assert clear_err and pop together → underflow remains 1.
- Push 0x5555 and assert reset in the same cycle with count=5 → count=0, pstack_top=0, flags 0. Subsequent push 0x0001 → pstack_top=0x0001, count=1.
